// File: rtl/lsu_multicycle.sv
// Load/store unit for the multicycle datapath: computes the effective
// address, builds byte enables and lane-shifted store data, runs one
// request/ready transaction with data memory and returns extended load data.
//
// Handshake: mem_req is high for the whole ACCESS state and every mem_*
// field is registered when the access starts, so the fields stay stable
// while mem_req is high. A transfer happens on the rising clk edge where
// mem_req=1 and mem_ready=1. mem_ready is ignored while mem_req=0.
module lsu_multicycle #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     base,
    input  logic [XLEN-1:0]     offset,
    input  logic [XLEN-1:0]     store_data,
    output logic                busy,
    output logic                done,
    output logic                misaligned,
    output logic                illegal,
    output logic [XLEN-1:0]     load_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ready,
    output logic [1:0]          dbg_state
);

    localparam int BE_W   = XLEN / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int SUM_W  = (XLEN > ADDR_W) ? XLEN : ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Request decode (valid while IDLE)
    logic [SUM_W-1:0]  ea_sum;
    logic [ADDR_W-1:0] ea;
    logic [LANE_W-1:0] lane;
    logic [1:0]        size_d;
    logic              req_legal;
    logic              req_mis;
    logic [7:0]        byte_mask8;
    logic [BE_W-1:0]   be_shift;
    logic [6:0]        nbits_d;
    logic [XLEN-1:0]   data_mask_d;
    logic [XLEN-1:0]   wdata_shift;

    // Per-access context kept for the load return path
    logic [LANE_W-1:0] lane_q;
    logic [1:0]        size_q;
    logic              sext_q;

    // Load extraction
    logic [6:0]        nbits_q;
    logic [XLEN-1:0]   data_mask_q;
    logic [XLEN-1:0]   rd_shift;
    logic              rd_sign;
    logic [XLEN-1:0]   load_ext;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_RESP);
    assign mem_req   = (state_q == S_ACCESS);
    assign dbg_state = state_q;

    // Decode size/legality/alignment and pre-shift enables and store data
    always_comb begin
        ea_sum    = SUM_W'(base) + SUM_W'(offset);
        ea        = ea_sum[ADDR_W-1:0];
        lane      = ea[LANE_W-1:0];
        size_d    = funct3[1:0];
        req_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b011:                 req_legal = (XLEN == 64);
            3'b100, 3'b101:         req_legal = !is_store;
            3'b110:                 req_legal = !is_store && (XLEN == 64);
            default:                req_legal = 1'b0;
        endcase
        req_mis = 1'b0;
        case (size_d)
            2'd1:    req_mis = ea[0];
            2'd2:    req_mis = (ea[1:0] != 2'd0);
            2'd3:    req_mis = (ea[2:0] != 3'd0);
            default: req_mis = 1'b0;
        endcase
        byte_mask8 = 8'h01;
        case (size_d)
            2'd0:    byte_mask8 = 8'h01;
            2'd1:    byte_mask8 = 8'h03;
            2'd2:    byte_mask8 = 8'h0F;
            default: byte_mask8 = 8'hFF;
        endcase
        be_shift    = BE_W'(byte_mask8) << lane;
        nbits_d     = 7'd8 << size_d;
        data_mask_d = ~({XLEN{1'b1}} << nbits_d);
        wdata_shift = (store_data & data_mask_d) << {lane, 3'b000};
    end

    // Extract the addressed field from the returned word and extend it
    always_comb begin
        nbits_q     = 7'd8 << size_q;
        data_mask_q = ~({XLEN{1'b1}} << nbits_q);
        rd_shift    = mem_rdata >> {lane_q, 3'b000};
        rd_sign     = 1'b0;
        case (size_q)
            2'd0:    rd_sign = rd_shift[7];
            2'd1:    rd_sign = rd_shift[15];
            2'd2:    rd_sign = rd_shift[31];
            default: rd_sign = rd_shift[XLEN-1];
        endcase
        load_ext = (rd_shift & data_mask_q) |
                   ((sext_q && rd_sign) ? ~data_mask_q : '0);
    end

    // State register; reset drops mem_req immediately since it decodes state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_legal && !req_mis) state_d = S_ACCESS;
                    else                       state_d = S_RESP;
                end
            end
            S_ACCESS: begin
                if (mem_ready) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture request fields on start, status flags, and load results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            load_data  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            lane_q     <= '0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                illegal    <= !req_legal;
                misaligned <= req_legal && req_mis;
                if (req_legal && !req_mis) begin
                    mem_we    <= is_store;
                    mem_addr  <= {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    mem_be    <= be_shift;
                    mem_wdata <= is_store ? wdata_shift : '0;
                    lane_q    <= lane;
                    size_q    <= size_d;
                    sext_q    <= !funct3[2];
                end
            end
            if (state_q == S_ACCESS && mem_ready && !mem_we) begin
                load_data <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_multicycle.sv
// Self-checking bench for lsu_multicycle (XLEN=32): a byte-level reference
// model predicts each request and response, a memory responder checks the
// request fields and inserts wait states, and a response monitor checks
// done/flags/load_data/latency against the expected queue.
module tb_lsu_multicycle;

    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int BW    = XLEN / 8;
    localparam int REQ_W = 1 + AW + BW + XLEN;
    localparam int RSP_W = 2 + XLEN;

    logic            clk;
    logic            rst;
    logic            start;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] store_data;
    logic            busy;
    logic            done;
    logic            misaligned;
    logic            illegal;
    logic [XLEN-1:0] load_data;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [BW-1:0]   mem_be;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic [1:0]      dbg_state;

    lsu_multicycle #(.XLEN(XLEN), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .funct3(funct3), .base(base), .offset(offset), .store_data(store_data),
        .busy(busy), .done(done), .misaligned(misaligned), .illegal(illegal),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [RSP_W-1:0] exp_q[$];      // {illegal, misaligned, load_data}
    int               exp_cyc_q[$];  // cycle in which done must be seen
    logic [REQ_W-1:0] req_q[$];      // {we, addr, be, wdata}
    int               wait_q[$];

    logic [31:0]     ref_mem[64];    // model's view of memory
    logic [31:0]     mem[64];        // memory seen by the DUT
    logic [XLEN-1:0] last_load;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Predicts the request and the response of one access from the ISA rules,
    // byte by byte, and applies stores to ref_mem.
    task automatic model_access(input logic st, input logic [2:0] f3, input logic [31:0] b,
                                input logic [31:0] o, input logic [31:0] sd,
                                input int waits, input int s_cyc);
        logic [31:0] ea;
        int          nb;
        int          lane;
        int          idx;
        bit          legal;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] v;
        ea    = b + o;
        nb    = 1 << f3[1:0];
        lane  = int'(ea % 4);
        idx   = int'(ea[7:2]);
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) begin
            exp_q.push_back({1'b1, 1'b0, last_load});
            exp_cyc_q.push_back(s_cyc + 1);
        end else if ((ea % nb) != 0) begin
            exp_q.push_back({1'b0, 1'b1, last_load});
            exp_cyc_q.push_back(s_cyc + 1);
        end else begin
            wd = '0;
            be = '0;
            v  = '0;
            for (int k = 0; k < nb; k++) begin
                be[lane+k] = 1'b1;
                wd[8*(lane+k) +: 8] = sd[8*k +: 8];
                v[8*k +: 8] = ref_mem[idx][8*(lane+k) +: 8];
            end
            if (st) begin
                for (int k = 0; k < nb; k++) ref_mem[idx][8*(lane+k) +: 8] = sd[8*k +: 8];
            end else begin
                if (!f3[2] && v[8*nb-1]) begin
                    for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
                end
                last_load = v;
            end
            req_q.push_back({st, {ea[31:2], 2'b00}, be, wd});
            wait_q.push_back(waits);
            exp_q.push_back({1'b0, 1'b0, last_load});
            exp_cyc_q.push_back(s_cyc + 2 + waits);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] b,
                             input logic [31:0] o, input logic [31:0] sd,
                             input int waits, input bit poke);
        int g;
        @(posedge clk); #1;
        is_store   = st;
        funct3     = f3;
        base       = b;
        offset     = o;
        store_data = sd;
        start      = 1'b1;
        model_access(st, f3, b, o, sd, waits, cyc);
        @(posedge clk); #1;
        start      = 1'b0;
        base       = $urandom;
        offset     = $urandom;
        store_data = $urandom;
        funct3     = 3'($urandom_range(0, 7));
        is_store   = 1'($urandom_range(0, 1));
        if (poke) begin
            // A second start while busy must be ignored
            @(posedge clk); #1;
            is_store = 1'b1;
            funct3   = 3'd2;
            base     = 32'h0000_0010;
            offset   = 32'h0;
            start    = 1'b1;
            @(posedge clk); #1;
            start    = 1'b0;
        end
        g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none expected=done (t=%0t)", $time);
            exp_q.delete();
            exp_cyc_q.delete();
            req_q.delete();
            wait_q.delete();
        end
    endtask

    // ---------------- memory responder / request checker ----------------
    bit               active = 1'b0;
    int               cnt    = 0;
    logic [REQ_W-1:0] cur_req;
    logic [REQ_W-1:0] held;
    always @(negedge clk) begin
        if (!rst) begin
            active    = 1'b0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (!active) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=req expected=no_req (t=%0t)", $time);
                    mem_ready = 1'b1;
                    cnt = 0;
                end else begin
                    cur_req = req_q.pop_front();
                    cnt     = wait_q.pop_front();
                    active  = 1'b1;
                    held    = {mem_we, mem_addr, mem_be, mem_wdata};
                    check("req_we",   64'(mem_we),   64'(cur_req[REQ_W-1]));
                    check("req_addr", 64'(mem_addr), 64'(cur_req[XLEN+BW +: AW]));
                    check("req_be",   64'(mem_be),   64'(cur_req[XLEN +: BW]));
                    if (cur_req[REQ_W-1]) check("req_wdata", 64'(mem_wdata), 64'(cur_req[XLEN-1:0]));
                end
            end else begin
                check("req_stable", 64'({mem_we, mem_addr, mem_be, mem_wdata}), 64'(held));
            end
            if (active) begin
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[7:2]];
                    if (mem_we) begin
                        for (int k = 0; k < BW; k++)
                            if (mem_be[k]) mem[mem_addr[7:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                    end
                    active = 1'b0;
                end else begin
                    cnt--;
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end else begin
            if (active) begin
                checks++;
                failures++;
                $display("FAIL req_dropped actual=0 expected=1 (t=%0t)", $time);
                active = 1'b0;
            end
            // mem_ready noise while no request is outstanding
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // ---------------- response monitor ----------------
    logic [RSP_W-1:0] exp_rsp;
    int               exp_c;
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_rsp = exp_q.pop_front();
                exp_c   = exp_cyc_q.pop_front();
                check("rsp_illegal",    64'(illegal),    64'(exp_rsp[RSP_W-1]));
                check("rsp_misaligned", 64'(misaligned), 64'(exp_rsp[RSP_W-2]));
                check("rsp_load_data",  64'(load_data),  64'(exp_rsp[XLEN-1:0]));
                check("rsp_latency",    64'(cyc),        64'(exp_c));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'd0;
        base       = '0;
        offset     = '0;
        store_data = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        last_load  = '0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            mem[i]     = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_busy",      64'(busy),       64'd0);
        check("rst_done",      64'(done),       64'd0);
        check("rst_flags",     64'({misaligned, illegal}), 64'd0);
        check("rst_load_data", 64'(load_data),  64'd0);
        check("rst_mem_req",   64'({mem_req, mem_we}), 64'd0);
        check("rst_mem_addr",  64'(mem_addr),   64'd0);
        check("rst_mem_wdata", 64'(mem_wdata),  64'd0);
        check("rst_mem_be",    64'(mem_be),     64'd0);

        // Directed accesses
        do_access(1'b1, 3'b010, 32'h80, 32'h8, 32'hCAFEBABE, 0, 1'b0);    // SW
        check("sw_mem_word22", 64'(mem[8'h22]), 64'h0000_0000_CAFE_BABE);
        do_access(1'b1, 3'b000, 32'h80, 32'h3, 32'h000000BE, 0, 1'b0);    // SB
        check("sb_mem_word20", 64'(mem[8'h20]), 64'h0000_0000_BE00_0000);
        do_access(1'b1, 3'b010, 32'h80, 32'h0, 32'h80011234, 1, 1'b0);    // SW setup
        do_access(1'b0, 3'b001, 32'h80, 32'h2, 32'h0, 0, 1'b0);           // LH
        check("lh_value",  64'(load_data), 64'h0000_0000_FFFF_8001);
        do_access(1'b0, 3'b101, 32'h80, 32'h2, 32'h0, 2, 1'b0);           // LHU
        check("lhu_value", 64'(load_data), 64'h0000_0000_0000_8001);
        do_access(1'b1, 3'b010, 32'h80, 32'h0, 32'h00007F00, 0, 1'b0);    // SW setup
        do_access(1'b0, 3'b000, 32'h80, 32'h1, 32'h0, 0, 1'b0);           // LB
        check("lb_value",  64'(load_data), 64'h0000_0000_0000_007F);
        do_access(1'b0, 3'b010, 32'h80, 32'h6, 32'h0, 0, 1'b0);           // LW misaligned
        do_access(1'b1, 3'b101, 32'h80, 32'h0, 32'h1234, 0, 1'b0);        // SH f3=101 illegal
        do_access(1'b0, 3'b010, 32'h88, 32'h0, 32'h0, 3, 1'b1);           // LW, waits, poke
        do_access(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h5A5A_A5A5, 0, 1'b0); // wrapping ea
        do_access(1'b0, 3'b010, 32'h0, 32'h4, 32'h0, 1, 1'b0);
        check("wrap_readback", 64'(load_data), 64'h0000_0000_5A5A_A5A5);

        // Reset in the middle of an access
        @(posedge clk); #1;
        is_store   = 1'b1;
        funct3     = 3'b010;
        base       = 32'h40;
        offset     = 32'h0;
        store_data = 32'h1111_2222;
        start      = 1'b1;
        req_q.push_back({1'b1, 32'h40, 4'hF, 32'h1111_2222});
        wait_q.push_back(6);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("rstmid_req_before", 64'(mem_req), 64'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rstmid_req_after",  64'(mem_req), 64'd0);
        check("rstmid_busy_after", 64'(busy),    64'd0);
        req_q.delete();
        wait_q.delete();
        last_load = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        check("rstmid_load_data", 64'(load_data), 64'd0);
        check("rstmid_no_write",  64'(mem[16]),   64'd0);
        do_access(1'b1, 3'b010, 32'h40, 32'h0, 32'h3333_4444, 0, 1'b0);
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 1'b0);
        check("post_rst_readback", 64'(load_data), 64'h0000_0000_3333_4444);

        // Randomized accesses
        for (int i = 0; i < 250; i++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 255)), 32'($urandom_range(0, 31)) - 32'd16,
                      $urandom, $urandom_range(0, 3), 1'b0);
        end

        repeat (4) @(posedge clk);
        check("queues_drained", 64'(exp_q.size() + req_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule

// File: doc/lsu_multicycle.md
Name: lsu_multicycle

Overview:
- Parametrised load/store unit for the multicycle RV32I datapath; generalises the word-only store path to byte, halfword, word and (XLEN=64) doubleword accesses.
- Computes the effective address, generates byte enables and lane-shifted write data, and runs a req/ready handshake with data memory.
- Sign- or zero-extends load data, flags misaligned accesses, and reports completion to the control FSM with a one-cycle done pulse.

Parameters:
- XLEN, 32, data/register width; legal values are 32 or 64.
- ADDR_W, 32, memory byte-address width; must be ≥ log2(XLEN/8)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately, release is synchronous to clk.
- start  input  1  begin access; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V size/sign encoding.
- base  input  XLEN  rs1 value.
- offset  input  XLEN  sign-extended immediate.
- store_data  input  XLEN  rs2 value.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  valid with done; access was aborted.
- illegal  output  1  valid with done; unsupported funct3.
- load_data  output  XLEN  extended load result; held until the next load completes.
- mem_req  output  1  memory request.
- mem_we  output  1  write strobe, qualifies mem_req.
- mem_addr  output  ADDR_W  naturally aligned to an XLEN/8-byte boundary.
- mem_wdata  output  XLEN  lane-shifted store data.
- mem_be  output  XLEN/8  byte enables.
- mem_rdata  input  XLEN  full-word read data; valid when mem_ready=1.
- mem_ready  input  1  completes the handshake.

Behaviour:
- Reset values: busy=0, done=0, misaligned=0, illegal=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Effective address: ea = (base + offset) truncated to ADDR_W bits; wraps modulo 2^ADDR_W with no error. All request fields are registered on start.
- funct3 decode:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - 011 = D and 110 = WU are legal only when XLEN=64.
  - Stores accept only funct3[2]=0.
  - Every other code is illegal.
- Alignment: H requires ea[0]=0; W requires ea[1:0]=0; D requires ea[2:0]=0.
- Lane offset: lane = ea mod (XLEN/8).
- Byte enables: mem_be = size mask << lane.
- Write data: mem_wdata = (store_data masked to size) << 8*lane.
- Load data: extract the size-wide field at 8*lane from mem_rdata, then sign-extend (B/H/W/D) or zero-extend (BU/HU/WU) to XLEN.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: start=1 with a legal, aligned request goes to ACCESS. mem_req=1 and all mem_* outputs are valid from the next cycle.
  - IDLE: start=1 with an illegal or misaligned request goes to RESP with the matching flag set and mem_req never asserted.
  - ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until a clk edge samples mem_ready=1. That edge captures load_data (loads only), drops mem_req, and moves to RESP.
  - RESP: done=1 for exactly one cycle, then IDLE. Flags clear on the next start.
- Latency: with zero-wait memory (mem_ready=1 combinationally in the first req cycle), done goes high 2 cycles after start. Each wait cycle adds 1.
- start while busy=1 is ignored. mem_ready while mem_req=0 is ignored.
- Stores never modify load_data. Loads drive mem_be with the access mask and mem_we=0.
- rst=0 mid-access: mem_req drops immediately (asynchronously), the FSM returns to IDLE, and no done is generated.

Test Plan:
- SW: base=80, offset=8, store_data=CAFEBABE, zero-wait → mem_addr=88, mem_be=1111, mem_wdata=CAFEBABE, mem_we=1; done exactly 2 cycles after start; memory word 22 = CAFEBABE.
- SB: base=80, offset=3, store_data=000000BE → mem_addr=80, mem_be=1000, mem_wdata=BE000000.
- LH at ea=82, mem_rdata=8001_1234 → load_data=FFFF8001. Same access as LHU → load_data=00008001. LB at ea=81, mem_rdata=0000_7F00 → 0000007F.
- Misaligned and illegal:
  - LW at ea=86 → done after 1 cycle, misaligned=1, mem_req never high.
  - SH with funct3=101 → illegal=1, mem_req never high.
- Wait states: mem_ready held low for 3 cycles → mem_* outputs stable throughout; done on the cycle after mem_ready; second start during busy is ignored.
- Reset mid-access: rst=0 while mem_req=1 → mem_req=0 immediately, busy=0, no done. A following SW after reset release completes normally.
